// File: rtl/id_ex_hazard_stage_pkg.sv
// id_ex_hazard_stage_pkg: shared pipeline widths, ALU op codes and the ID/EX control bundle
package id_ex_hazard_stage_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int ALUOP_W = 4;
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;
endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// id_ex_hazard_stage_if: ID-side inputs and EX-side outputs of the ID/EX stage
// master drives id_*, flush, ex_hold and sees stall/ex_*/stall_cnt; slave is the stage itself
interface id_ex_hazard_stage_if import id_ex_hazard_stage_pkg::*; #(parameter int CNT_W = 16);
  logic id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic id_uses_rs, id_uses_rt;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [ALUOP_W-1:0] id_alu_op;
  logic flush, ex_hold, stall, ex_valid;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
           flush, ex_hold,
    input  stall, ex_valid, ex_rs, ex_rt, ex_dest, ex_rs_data, ex_rt_data, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
           flush, ex_hold,
    output stall, ex_valid, ex_rs, ex_rt, ex_dest, ex_rs_data, ex_rt_data, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op, stall_cnt
  );
endinterface

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// id_ex_hazard_stage_load_use_detect: combinational load-use compare of the EX load against ID sources
// in: ex_valid/ex_mem_read/ex_dest (load in EX), id_valid/id_uses_*/id_rs/id_rt (ID reader); out: load_use
module id_ex_hazard_stage_load_use_detect import id_ex_hazard_stage_pkg::*; (
  input  logic ex_valid,
  input  logic ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic id_valid,
  input  logic id_uses_rs,
  input  logic id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic load_use
);
  assign load_use = ex_valid & ex_mem_read & (ex_dest != '0) & id_valid &
                    ((id_uses_rs & (ex_dest == id_rs)) | (id_uses_rt & (ex_dest == id_rt)));
endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall, bubble insertion, flush and hold
// ports: clk, rst_n (async active-low), bus (slave view: id_* in, stall/ex_*/stall_cnt out)
module id_ex_hazard_stage import id_ex_hazard_stage_pkg::*; #(parameter int CNT_W = 16) (
  input  logic clk,
  input  logic rst_n,
  id_ex_hazard_stage_if.slave bus
);
  id_ex_ctrl_t ctrl, id_ctrl;
  logic valid, load_use;
  logic [REG_AW-1:0] rs, rt, dest;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [CNT_W-1:0] cnt;
  // write enables from an empty ID slot are dropped so they always imply ex_valid
  assign id_ctrl = '{reg_write: bus.id_reg_write & bus.id_valid, mem_read: bus.id_mem_read,
                     mem_write: bus.id_mem_write & bus.id_valid, mem_to_reg: bus.id_mem_to_reg,
                     alu_src: bus.id_alu_src, alu_op: bus.id_alu_op};
  id_ex_hazard_stage_load_use_detect u_detect (
    .ex_valid(valid), .ex_mem_read(ctrl.mem_read), .ex_dest(dest),
    .id_valid(bus.id_valid), .id_uses_rs(bus.id_uses_rs), .id_uses_rt(bus.id_uses_rt),
    .id_rs(bus.id_rs), .id_rt(bus.id_rt), .load_use(load_use)
  );
  assign bus.stall = rst_n & (load_use | bus.ex_hold) & ~bus.flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl <= '0;
      rs <= '0;
      rt <= '0;
      dest <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      valid <= 1'b0;
      ctrl <= '0;
    end else if (bus.ex_hold) begin
      valid <= valid;
    end else if (load_use) begin
      // bubble specifiers are zeroed so forwarding never matches them
      valid <= 1'b0;
      ctrl <= '0;
      rs <= '0;
      rt <= '0;
      dest <= '0;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
    end else begin
      valid <= bus.id_valid;
      ctrl <= id_ctrl;
      rs <= bus.id_rs;
      rt <= bus.id_rt;
      dest <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      rs_data <= bus.id_rs_data;
      rt_data <= bus.id_rt_data;
      imm <= bus.id_imm;
    end
  end
  assign bus.ex_valid = valid;
  assign bus.ex_rs = rs;
  assign bus.ex_rt = rt;
  assign bus.ex_dest = dest;
  assign bus.ex_rs_data = rs_data;
  assign bus.ex_rt_data = rt_data;
  assign bus.ex_imm = imm;
  assign bus.ex_reg_write = ctrl.reg_write;
  assign bus.ex_mem_read = ctrl.mem_read;
  assign bus.ex_mem_write = ctrl.mem_write;
  assign bus.ex_mem_to_reg = ctrl.mem_to_reg;
  assign bus.ex_alu_src = ctrl.alu_src;
  assign bus.ex_alu_op = ctrl.alu_op;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: directed vectors with hand-computed expectations for id_ex_hazard_stage
module tb_id_ex_hazard_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  id_ex_hazard_stage_if #(.CNT_W(3)) bus();
  id_ex_hazard_stage #(.CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rdst, input logic rw, input logic mr,
                        input logic [31:0] rsd);
    bus.id_valid = v;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_reg_dst = rdst;
    bus.id_reg_write = rw;
    bus.id_mem_read = mr;
    bus.id_mem_write = 1'b0;
    bus.id_mem_to_reg = mr;
    bus.id_alu_src = mr;
    bus.id_alu_op = 4'h1;
    bus.id_rs_data = rsd;
    bus.id_rt_data = rsd + 32'd1;
    bus.id_imm = rsd ^ 32'hff;
  endtask
  task automatic load_lw(input logic [4:0] d);
    set_id(1'b1, 5'd1, d, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h99);
    tick();
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11);
    #1 check("cap_stall", bus.stall, 0);
    tick();
    check("cap_valid", bus.ex_valid, 1);
    check("cap_rs", bus.ex_rs, 3);
    check("cap_rt", bus.ex_rt, 4);
    check("cap_dest", bus.ex_dest, 5);
    check("cap_rw", bus.ex_reg_write, 1);
    check("cap_rsd", bus.ex_rs_data, 32'h11);
    check("cap_rtd", bus.ex_rt_data, 32'h12);
    bus.ex_hold = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.ex_valid, 0);
    check("rst_rs", bus.ex_rs, 0);
    check("rst_dest", bus.ex_dest, 0);
    check("rst_rw", bus.ex_reg_write, 0);
    check("rst_rsd", bus.ex_rs_data, 0);
    check("rst_cnt", bus.stall_cnt, 0);
    check("rst_stall", bus.stall, 0);
    bus.ex_hold = 1'b0;
    rst_n = 1'b1;
    load_lw(5'd8);
    check("lw_dest", bus.ex_dest, 8);
    check("lw_mr", bus.ex_mem_read, 1);
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h22);
    #1 check("lu_stall", bus.stall, 1);
    tick();
    check("bub_valid", bus.ex_valid, 0);
    check("bub_rs", bus.ex_rs, 0);
    check("bub_rt", bus.ex_rt, 0);
    check("bub_dest", bus.ex_dest, 0);
    check("bub_mr", bus.ex_mem_read, 0);
    check("bub_rw", bus.ex_reg_write, 0);
    check("bub_cnt", bus.stall_cnt, 1);
    check("bub_stall", bus.stall, 0);
    tick();
    check("after_rs", bus.ex_rs, 8);
    check("after_dest", bus.ex_dest, 9);
    check("after_valid", bus.ex_valid, 1);
    check("after_rsd", bus.ex_rs_data, 32'h22);
    load_lw(5'd0);
    set_id(1'b1, 5'd0, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h23);
    #1 check("nh_r0", bus.stall, 0);
    tick();
    load_lw(5'd8);
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h24);
    #1 check("nh_nouse", bus.stall, 0);
    tick();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h25);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h26);
    #1 check("nh_nomr", bus.stall, 0);
    tick();
    check("nh_cnt", bus.stall_cnt, 1);
    load_lw(5'd8);
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h27);
    bus.flush = 1'b1;
    #1 check("fl_stall", bus.stall, 0);
    tick();
    bus.flush = 1'b0;
    check("fl_valid", bus.ex_valid, 0);
    check("fl_rw", bus.ex_reg_write, 0);
    check("fl_mr", bus.ex_mem_read, 0);
    check("fl_cnt", bus.stall_cnt, 1);
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33);
    tick();
    check("pre_hold_rs", bus.ex_rs, 3);
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(10 + i), 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40 + 32'(i));
      #1 check("hold_stall", bus.stall, 1);
      tick();
      check("hold_rs", bus.ex_rs, 3);
      check("hold_rsd", bus.ex_rs_data, 32'h33);
      check("hold_rw", bus.ex_reg_write, 1);
    end
    bus.ex_hold = 1'b0;
    tick();
    check("rel_rs", bus.ex_rs, 12);
    check("rel_rsd", bus.ex_rs_data, 32'h42);
    check("rel_dest", bus.ex_dest, 6);
    check("rel_rw", bus.ex_reg_write, 0);
    for (int i = 0; i < 6; i++) begin
      load_lw(5'd8);
      set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50);
      tick();
      tick();
    end
    check("sat_full", bus.stall_cnt, 7);
    load_lw(5'd8);
    set_id(1'b1, 5'd2, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h51);
    #1 check("sat_stall_rt", bus.stall, 1);
    tick();
    check("sat_hold", bus.stall_cnt, 7);
    check("sat_bub_valid", bus.ex_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
